// File: rtl/mult32x32_pkg.sv
// Shared types and constants for the 32x32 multiplier sequencer.
package mult32x32_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int NUM_STEPS   = 8;
  localparam int STEP_W      = 3;
  localparam int A_SEL_W     = 2;
  localparam int SHIFT_SEL_W = 3;

  // Shifter select in units of 8 bits: a byte moves 8 bits, a B half moves 16.
  function automatic logic [SHIFT_SEL_W-1:0] shift_of(input logic [A_SEL_W-1:0] a_sel,
                                                      input logic b_sel);
    return {1'b0, a_sel} + {1'b0, b_sel, 1'b0};
  endfunction

endpackage

// File: rtl/mult32x32_next_step.sv
// Priority finder: lowest eligible step, either from scratch or strictly after cur_i.
module mult32x32_next_step
  import mult32x32_pkg::*;
(
  input  logic [NUM_STEPS-1:0] elig_i,
  input  logic [STEP_W-1:0]    cur_i,
  input  logic                 from_start_i,
  output logic [STEP_W-1:0]    nxt_o,
  output logic                 found_o
);

  // Scan high to low so the lowest qualifying step is the last one written.
  always_comb begin
    nxt_o   = '0;
    found_o = 1'b0;
    for (int k = NUM_STEPS - 1; k >= 0; k--) begin
      if (elig_i[k] && (from_start_i || (k > int'(cur_i)))) begin
        nxt_o   = STEP_W'(k);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult32x32_ctrl.sv
// Sequencer for the 16x8 partial-product multiplier: clear, up to 8 accumulate steps, done.
module mult32x32_ctrl
  import mult32x32_pkg::*;
#(
  parameter int SKIP_ZERO = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            a,
  input  logic [31:0]            b,
  output logic                   busy,
  output logic                   done,
  output logic [A_SEL_W-1:0]     a_sel,
  output logic                   b_sel,
  output logic [SHIFT_SEL_W-1:0] shift_sel,
  output logic                   upd_prod,
  output logic                   clr_prod
);

  state_e              state_q;
  logic [STEP_W-1:0]   step_q;
  logic [STEP_W-1:0]   step_d;
  logic                found;
  logic [NUM_STEPS-1:0] elig;

  // Step k uses A byte k[1:0] and B half k[2]; a zero operand slice makes the step a no-op.
  for (genvar k = 0; k < NUM_STEPS; k++) begin : g_elig
    localparam int AB = k % 4;
    localparam int BH = k / 4;
    assign elig[k] = (SKIP_ZERO == 0) ||
                     ((a[8*AB +: 8] != 8'h00) && (b[16*BH +: 16] != 16'h0000));
  end

  // Outside RUN the search starts from step 0, inside RUN it looks past the current step.
  mult32x32_next_step u_next (
    .elig_i       (elig),
    .cur_i        (step_q),
    .from_start_i (state_q != RUN),
    .nxt_o        (step_d),
    .found_o      (found)
  );

  // State and step register; DONE with start chains straight into a new run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= found ? RUN : DONE;
            step_q  <= found ? step_d : '0;
          end else begin
            state_q <= IDLE;
            step_q  <= '0;
          end
        end
        RUN: begin
          state_q <= found ? RUN : DONE;
          step_q  <= found ? step_d : '0;
        end
        default: begin
          state_q <= IDLE;
          step_q  <= '0;
        end
      endcase
    end
  end

  // Datapath controls decoded from state/step; clear is a same-cycle response to start.
  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    upd_prod  = (state_q == RUN);
    a_sel     = '0;
    b_sel     = 1'b0;
    shift_sel = '0;
    clr_prod  = (state_q != RUN) && start && !reset;
    if (state_q == RUN) begin
      a_sel     = step_q[A_SEL_W-1:0];
      b_sel     = step_q[STEP_W-1];
      shift_sel = shift_of(step_q[A_SEL_W-1:0], step_q[STEP_W-1]);
    end
  end

endmodule

// File: tb/tb_mult32x32_ctrl.sv
// Bench for mult32x32_ctrl: one instance per SKIP_ZERO setting plus a product-register model.
module tb_mult32x32_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [31:0] a = '0, b = '0;

  logic       busy0, done0, bsel0, upd0, clr0;
  logic [1:0] asel0;
  logic [2:0] ssel0;
  logic       busy1, done1, bsel1, upd1, clr1;
  logic [1:0] asel1;
  logic [2:0] ssel1;

  mult32x32_ctrl #(.SKIP_ZERO(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .a(a), .b(b),
    .busy(busy0), .done(done0), .a_sel(asel0), .b_sel(bsel0),
    .shift_sel(ssel0), .upd_prod(upd0), .clr_prod(clr0)
  );

  mult32x32_ctrl #(.SKIP_ZERO(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a), .b(b),
    .busy(busy1), .done(done1), .a_sel(asel1), .b_sel(bsel1),
    .shift_sel(ssel1), .upd_prod(upd1), .clr_prod(clr1)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit sel = 1'b0;

  // Observed outputs of the instance under test.
  logic       o_busy, o_done, o_bsel, o_upd, o_clr;
  logic [1:0] o_asel;
  logic [2:0] o_ssel;
  assign o_busy = sel ? busy1 : busy0;
  assign o_done = sel ? done1 : done0;
  assign o_bsel = sel ? bsel1 : bsel0;
  assign o_upd  = sel ? upd1  : upd0;
  assign o_clr  = sel ? clr1  : clr0;
  assign o_asel = sel ? asel1 : asel0;
  assign o_ssel = sel ? ssel1 : ssel0;

  // Datapath product register model: clear, or add byte*half shifted by 8*shift_sel.
  logic [63:0] prod0 = '0, prod1 = '0;
  always @(posedge clk or posedge reset) begin
    if (reset) prod0 <= '0;
    else if (clr0) prod0 <= '0;
    else if (upd0) prod0 <= prod0 + ((64'(a[8*asel0 +: 8]) * 64'(b[16*bsel0 +: 16])) << (8*ssel0));
  end
  always @(posedge clk or posedge reset) begin
    if (reset) prod1 <= '0;
    else if (clr1) prod1 <= '0;
    else if (upd1) prod1 <= prod1 + ((64'(a[8*asel1 +: 8]) * 64'(b[16*bsel1 +: 16])) << (8*ssel1));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check every control output; selects are expected only while busy.
  task automatic chk_out(input string tag, input bit be, input bit de, input bit ue,
                         input bit ce, input int k);
    int as_e, bs_e;
    as_e = be ? k % 4 : 0;
    bs_e = be ? k / 4 : 0;
    chk({tag, ".busy"},  64'(o_busy), 64'(be));
    chk({tag, ".done"},  64'(o_done), 64'(de));
    chk({tag, ".upd"},   64'(o_upd),  64'(ue));
    chk({tag, ".clr"},   64'(o_clr),  64'(ce));
    chk({tag, ".a_sel"}, 64'(o_asel), 64'(as_e));
    chk({tag, ".b_sel"}, 64'(o_bsel), 64'(bs_e));
    chk({tag, ".shift"}, 64'(o_ssel), 64'(as_e + 2 * bs_e));
  endtask

  task automatic set_start(input bit v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  // One multiplication. pre: start/operands already raised in the previous DONE cycle.
  // poke: raise start during the second RUN cycle. chain: raise start with next operands
  // so the DONE cycle also starts the next run.
  task automatic run(input bit s, input logic [31:0] av, input logic [31:0] bv,
                     input bit pre, input bit poke, input bit chain,
                     input logic [31:0] na, input logic [31:0] nb);
    int q[$];
    for (int k = 0; k < 8; k++) begin
      logic [31:0] ab, bh;
      ab = (av >> (8 * (k % 4))) & 32'hFF;
      bh = (bv >> (16 * (k / 4))) & 32'hFFFF;
      if (!s || (ab != 0 && bh != 0)) q.push_back(k);
    end
    sel = s;
    if (!pre) begin
      @(posedge clk); #1;
      a = av; b = bv; set_start(1'b1);
      @(negedge clk);
      chk_out("start", 0, 0, 0, 1, 0);
    end
    @(posedge clk); #1;
    if (chain && q.size() == 0) begin a = na; b = nb; set_start(1'b1); end
    else set_start(1'b0);
    for (int i = 0; i < q.size(); i++) begin
      if (poke && i == 1) set_start(1'b1);
      @(negedge clk);
      chk_out("run", 1, 0, 1, 0, q[i]);
      @(posedge clk); #1;
      if (chain && i == q.size() - 1) begin a = na; b = nb; set_start(1'b1); end
      else set_start(1'b0);
    end
    @(negedge clk);
    chk_out("done", 0, 1, 0, chain, 0);
    chk("product", sel ? prod1 : prod0, 64'(av) * 64'(bv));
  endtask

  task automatic idle_gap();
    @(posedge clk); #1;
    @(negedge clk);
    chk_out("idle", 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rnd_word(input int slices);
    logic [31:0] w;
    w = $urandom;
    for (int i = 0; i < slices; i++)
      if ($urandom_range(0, 2) == 0) w &= ~(((slices == 4) ? 32'hFF : 32'hFFFF) << ((32 / slices) * i));
    return w;
  endfunction

  initial begin
    // Reset state, including start high during reset.
    start0 = 1'b1;
    #12;
    sel = 1'b0; chk_out("rst0", 0, 0, 0, 0, 0);
    sel = 1'b1; chk_out("rst1", 0, 0, 0, 0, 0);
    start0 = 1'b0;
    @(negedge clk); #1 reset = 1'b0;

    // Full 8-step sequence.
    run(0, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0, '0, '0);
    idle_gap();
    // Zero-skip with a single live step.
    run(1, 32'h00FF0000, 32'h0000FFFF, 0, 0, 0, '0, '0);
    idle_gap();
    // Zero-skip with nothing to do: straight to DONE.
    run(1, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, '0, '0);
    idle_gap();
    // Back-to-back, with a start poke inside RUN.
    run(0, 32'h12345678, 32'h9ABCDEF0, 0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0, '0, '0);
    idle_gap();
    run(1, 32'h00000001, 32'h00010000, 0, 1, 1, 32'h80000001, 32'hFFFF0001);
    run(1, 32'h80000001, 32'hFFFF0001, 1, 0, 0, '0, '0);
    idle_gap();

    // Reset in RUN at step 4.
    sel = 1'b0;
    @(posedge clk); #1;
    a = 32'hDEADBEEF; b = 32'hCAFEF00D; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk_out("pre_rst", 1, 0, 1, 0, i);
      @(posedge clk); #1;
    end
    @(negedge clk); chk_out("step4", 1, 0, 1, 0, 4);
    #1 reset = 1'b1;
    #1 chk_out("async_rst", 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk_out("post_rst", 0, 0, 0, 0, 0);
    end
    run(0, 32'hDEADBEEF, 32'hCAFEF00D, 0, 0, 0, '0, '0);
    idle_gap();

    // Randomized operands with sparse zero slices on both instances.
    for (int n = 0; n < 30; n++) begin
      bit s;
      logic [31:0] av, bv;
      s  = 1'($urandom_range(0, 1));
      av = rnd_word(4);
      bv = rnd_word(2);
      run(s, av, bv, 0, 1'($urandom_range(0, 1)), 0, '0, '0);
      idle_gap();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
